// File: rtl/ahb_ram_ctrl_1024x64.sv
// AHB-Lite slave driving a 1024x64 synchronous SRAM port, with a one-cycle stall when a read follows a write.
// Optional misalignment/size error response is enabled by defining AHB_RAM_ERR_EN.
module ahb_ram_ctrl_1024x64 #(
  parameter int AW = 13,
  parameter int DW = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic          HREADY,
  input  logic [DW-1:0] HWDATA,
  output logic [DW-1:0] HRDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic          RAM_EN,
  output logic [7:0]    RAM_WE,
  output logic [AW-4:0] RAM_A,
  output logic [DW-1:0] RAM_DI,
  input  logic [DW-1:0] RAM_DO
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_RDATA  = 3'd2,
    S_RSTALL = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_t;

  state_t        r_state;
  logic [AW-4:0] r_addr;
  logic [7:0]    r_mask;
  logic          r_hreadyout;
  logic          r_hresp;

  logic          w_accept;
  logic          w_err;
  logic [7:0]    w_mask;
  logic          w_unused;

  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

`ifdef AHB_RAM_ERR_EN
  function automatic logic xfer_err(input logic [2:0] size, input logic [2:0] off);
    logic bad;
    case (size)
      3'd0:    bad = 1'b0;
      3'd1:    bad = off[0];
      3'd2:    bad = |off[1:0];
      3'd3:    bad = |off[2:0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign w_err = xfer_err(HSIZE, HADDR[2:0]);
`else
  assign w_err = 1'b0;
`endif

  assign w_accept  = HSEL & HTRANS[1] & HREADY;
  assign w_mask    = lane_mask(HSIZE, HADDR[2:0]);
  assign w_unused  = HTRANS[0];

  assign HRDATA    = RAM_DO;
  assign RAM_DI    = HWDATA;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

  // RAM port: the captured address owns the port during WDATA/RSTALL, otherwise reads issue straight from the bus
  always_comb begin
    RAM_EN = 1'b0;
    RAM_WE = 8'h00;
    RAM_A  = HADDR[AW-1:3];
    case (r_state)
      S_WDATA: begin
        RAM_EN = 1'b1;
        RAM_WE = r_mask;
        RAM_A  = r_addr;
      end
      S_RSTALL: begin
        RAM_EN = 1'b1;
        RAM_A  = r_addr;
      end
      default: begin
        RAM_EN = w_accept & ~HWRITE & ~w_err;
      end
    endcase
    if (RST) begin
      RAM_EN = 1'b0;
      RAM_WE = 8'h00;
    end else begin
      RAM_EN = RAM_EN;
    end
  end

  // Transfer sequencing with registered bus handshake
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_mask      <= 8'h00;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      case (r_state)
        S_RSTALL: begin
          r_state     <= S_RDATA;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          if (w_accept && w_err) begin
            r_state     <= S_ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b1;
          end else if (w_accept && HWRITE) begin
            r_state     <= S_WDATA;
            r_addr      <= HADDR[AW-1:3];
            r_mask      <= w_mask;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end else if (w_accept && (r_state == S_WDATA)) begin
            // Port is busy committing the write; replay the read next cycle
            r_state     <= S_RSTALL;
            r_addr      <= HADDR[AW-1:3];
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b0;
          end else if (w_accept) begin
            r_state     <= S_RDATA;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_ram_ctrl_1024x64.sv
// Directed bench for ahb_ram_ctrl_1024x64 with a behavioural 1024x64 SRAM model.
module tb_ahb_ram_ctrl_1024x64;

  logic        CLK;
  logic        RST;
  logic        HSEL;
  logic [12:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        RAM_EN;
  logic [7:0]  RAM_WE;
  logic [9:0]  RAM_A;
  logic [63:0] RAM_DI;
  logic [63:0] RAM_DO;

  logic [63:0] mem [0:1023];
  int n_tests;
  int n_fail;

  ahb_ram_ctrl_1024x64 dut (
    .CLK(CLK), .RST(RST), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
  );

  assign HREADY = HREADYOUT;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous SRAM: byte-lane writes, read data one cycle after EN with WE=0
  always @(posedge CLK) begin
    if (RAM_EN) begin
      if (RAM_WE == 8'h00) RAM_DO <= mem[RAM_A];
      for (int b = 0; b < 8; b++)
        if (RAM_WE[b]) mem[RAM_A][8*b +: 8] <= RAM_DI[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [12:0] addr);
    HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    drive(1'b1, 2'b10, 1'b0, 3'd3, 13'h0008);
    #1;
    n_tests++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL rst_hreadyout got %b exp 1", HREADYOUT); end
    n_tests++; if (HRESP !== 1'b0) begin n_fail++; $display("FAIL rst_hresp got %b exp 0", HRESP); end
    n_tests++; if (RAM_EN !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en got %b exp 0", RAM_EN); end
    n_tests++; if (RAM_WE !== 8'h00) begin n_fail++; $display("FAIL rst_ram_we got %h exp 00", RAM_WE); end
    tick();
    RST = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 3'd0, 13'h0000);
    tick();
  endtask

  task automatic test_dword_write();
    tick();
    drive(1'b1, 2'b10, 1'b1, 3'd3, 13'h0008);
    #1;
    n_tests++; if (RAM_EN !== 1'b0) begin n_fail++; $display("FAIL dw_addr_en got %b exp 0", RAM_EN); end
    tick();
    drive(1'b0, 2'b00, 1'b0, 3'd0, 13'h0000);
    HWDATA = 64'h1122_3344_5566_7788;
    #1;
    n_tests++; if (RAM_EN !== 1'b1) begin n_fail++; $display("FAIL dw_en got %b exp 1", RAM_EN); end
    n_tests++; if (RAM_WE !== 8'hFF) begin n_fail++; $display("FAIL dw_we got %h exp ff", RAM_WE); end
    n_tests++; if (RAM_A !== 10'd1) begin n_fail++; $display("FAIL dw_a got %0d exp 1", RAM_A); end
    n_tests++; if (RAM_DI !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL dw_di got %h exp 1122334455667788", RAM_DI); end
    n_tests++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL dw_ready got %b exp 1", HREADYOUT); end
    tick();
    n_tests++; if (mem[1] !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL dw_mem got %h exp 1122334455667788", mem[1]); end
  endtask

  task automatic test_write_read_stall();
    tick();
    drive(1'b1, 2'b10, 1'b1, 3'd0, 13'h0013);
    tick();
    drive(1'b1, 2'b10, 1'b0, 3'd3, 13'h0010);
    HWDATA = 64'h0000_0000_AB00_0000;
    #1;
    n_tests++; if (RAM_WE !== 8'h08) begin n_fail++; $display("FAIL wr_byte_we got %h exp 08", RAM_WE); end
    n_tests++; if (RAM_A !== 10'd2) begin n_fail++; $display("FAIL wr_byte_a got %0d exp 2", RAM_A); end
    n_tests++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL wr_byte_ready got %b exp 1", HREADYOUT); end
    tick();
    drive(1'b0, 2'b00, 1'b0, 3'd0, 13'h0000);
    #1;
    n_tests++; if (HREADYOUT !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b exp 0", HREADYOUT); end
    n_tests++; if (RAM_EN !== 1'b1 || RAM_WE !== 8'h00) begin n_fail++; $display("FAIL stall_port got en=%b we=%h exp en=1 we=00", RAM_EN, RAM_WE); end
    n_tests++; if (RAM_A !== 10'd2) begin n_fail++; $display("FAIL stall_a got %0d exp 2", RAM_A); end
    tick();
    n_tests++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL stall_done_ready got %b exp 1", HREADYOUT); end
    n_tests++; if (HRDATA !== 64'hDEAD_BEEF_AB00_0002) begin n_fail++; $display("FAIL stall_rdata got %h exp deadbeefab000002", HRDATA); end
  endtask

  task automatic test_read_after_idle();
    tick();
    drive(1'b1, 2'b10, 1'b0, 3'd3, 13'h0000);
    #1;
    n_tests++; if (RAM_EN !== 1'b1 || RAM_WE !== 8'h00 || RAM_A !== 10'd0) begin n_fail++; $display("FAIL rd_issue got en=%b we=%h a=%0d exp en=1 we=00 a=0", RAM_EN, RAM_WE, RAM_A); end
    tick();
    drive(1'b0, 2'b00, 1'b0, 3'd0, 13'h0000);
    #1;
    n_tests++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL rd_ready got %b exp 1", HREADYOUT); end
    n_tests++; if (HRDATA !== 64'hDEAD_BEEF_0000_0000) begin n_fail++; $display("FAIL rd_data got %h exp deadbeef00000000", HRDATA); end
  endtask

  task automatic test_idle_busy();
    tick();
    drive(1'b1, 2'b01, 1'b0, 3'd3, 13'h0008);
    #1;
    n_tests++; if (RAM_EN !== 1'b0) begin n_fail++; $display("FAIL busy_en got %b exp 0", RAM_EN); end
    tick();
    drive(1'b0, 2'b10, 1'b0, 3'd3, 13'h0008);
    #1;
    n_tests++; if (RAM_EN !== 1'b0) begin n_fail++; $display("FAIL nosel_en got %b exp 0", RAM_EN); end
    tick();
    drive(1'b0, 2'b00, 1'b0, 3'd0, 13'h0000);
    #1;
    n_tests++; if (RAM_EN !== 1'b0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin n_fail++; $display("FAIL nosel_after got en=%b rdy=%b resp=%b exp 0 1 0", RAM_EN, HREADYOUT, HRESP); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] wd [0:3];
    logic [7:0]  exp_we [0:3];
    logic [9:0]  exp_a [0:3];
    wd[0] = 64'h0000_0000_1111_1111; wd[1] = 64'h2222_2222_0000_0000;
    wd[2] = 64'h0000_0000_3333_3333; wd[3] = 64'h4444_4444_0000_0000;
    exp_we[0] = 8'h0F; exp_we[1] = 8'hF0; exp_we[2] = 8'h0F; exp_we[3] = 8'hF0;
    exp_a[0] = 10'd0; exp_a[1] = 10'd0; exp_a[2] = 10'd1; exp_a[3] = 10'd1;
    tick();
    drive(1'b1, 2'b10, 1'b1, 3'd2, 13'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) drive(1'b1, 2'b10, 1'b1, 3'd2, 13'(4 * (i + 1)));
      else drive(1'b0, 2'b00, 1'b0, 3'd0, 13'h0000);
      HWDATA = wd[i];
      #1;
      n_tests++; if (RAM_WE !== exp_we[i] || RAM_A !== exp_a[i] || HREADYOUT !== 1'b1) begin
        n_fail++; $display("FAIL b2b_%0d got we=%h a=%0d rdy=%b exp we=%h a=%0d rdy=1", i, RAM_WE, RAM_A, HREADYOUT, exp_we[i], exp_a[i]);
      end
    end
    tick();
    n_tests++; if (mem[0] !== 64'h2222_2222_1111_1111) begin n_fail++; $display("FAIL b2b_mem0 got %h exp 2222222211111111", mem[0]); end
    n_tests++; if (mem[1] !== 64'h4444_4444_3333_3333) begin n_fail++; $display("FAIL b2b_mem1 got %h exp 4444444433333333", mem[1]); end
  endtask

  task automatic test_reset_mid_write();
    tick();
    drive(1'b1, 2'b10, 1'b1, 3'd3, 13'h0020);
    tick();
    drive(1'b0, 2'b00, 1'b0, 3'd0, 13'h0000);
    HWDATA = 64'hFFFF_FFFF_FFFF_FFFF;
    RST = 1'b1;
    #1;
    n_tests++; if (RAM_WE !== 8'h00 || RAM_EN !== 1'b0) begin n_fail++; $display("FAIL rstmid_port got en=%b we=%h exp en=0 we=00", RAM_EN, RAM_WE); end
    n_tests++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", HREADYOUT); end
    tick();
    RST = 1'b0;
    tick();
    drive(1'b1, 2'b10, 1'b0, 3'd3, 13'h0020);
    tick();
    drive(1'b0, 2'b00, 1'b0, 3'd0, 13'h0000);
    #1;
    n_tests++; if (HRDATA !== 64'hDEAD_BEEF_0000_0004) begin n_fail++; $display("FAIL rstmid_old got %h exp deadbeef00000004", HRDATA); end
  endtask

  task automatic test_error();
    tick();
    drive(1'b1, 2'b10, 1'b1, 3'd2, 13'h0002);
    tick();
    drive(1'b0, 2'b00, 1'b0, 3'd0, 13'h0000);
    HWDATA = 64'h0000_0000_0000_0000;
    #1;
`ifdef AHB_RAM_ERR_EN
    n_tests++; if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin n_fail++; $display("FAIL err1 got rdy=%b resp=%b exp rdy=0 resp=1", HREADYOUT, HRESP); end
    n_tests++; if (RAM_EN !== 1'b0 || RAM_WE !== 8'h00) begin n_fail++; $display("FAIL err1_port got en=%b we=%h exp 0 00", RAM_EN, RAM_WE); end
    tick();
    n_tests++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b1 || RAM_EN !== 1'b0) begin n_fail++; $display("FAIL err2 got rdy=%b resp=%b en=%b exp 1 1 0", HREADYOUT, HRESP, RAM_EN); end
    tick();
    n_tests++; if (HRESP !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", HRESP); end
`else
    n_tests++; if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL noerr got rdy=%b resp=%b exp 1 0", HREADYOUT, HRESP); end
    n_tests++; if (RAM_WE !== 8'h3C) begin n_fail++; $display("FAIL noerr_we got %h exp 3c", RAM_WE); end
    tick();
    n_tests++; if (HRESP !== 1'b0) begin n_fail++; $display("FAIL noerr_after got %b exp 0", HRESP); end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RST     = 1'b1;
    HWDATA  = 64'h0;
    drive(1'b0, 2'b00, 1'b0, 3'd0, 13'h0000);
    for (int i = 0; i < 1024; i++) mem[i] <= 64'hDEAD_BEEF_0000_0000 | 64'(i);
    test_reset();
    test_dword_write();
    test_write_read_stall();
    test_read_after_idle();
    test_idle_busy();
    test_back_to_back();
    test_reset_mid_write();
    test_error();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
